// File: rtl/shift_stage_pkg.sv
// Shared types for the shift result stage: per-entry flags and buffered entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package shift_stage_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } flags_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] y;
    flags_t               flags;
  } entry_t;

endpackage

// File: rtl/shift_flags.sv
// Flags and expected-result check for a left logic shift result.
// Latency: combinational.
// Backpressure: none; pure function of a/shift/y.
module shift_flags
  import shift_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] shift,
  input  logic [WIDTH-1:0] y,
  output flags_t           flags,
  output logic             mismatch
);

  logic [WIDTH-1:0] w_exp;
  logic             w_c;

  // Carry is the last bit shifted out of the top; nothing leaves for shift=0 or shift>WIDTH.
  always_comb begin
    w_exp = '0;
    w_c   = 1'b0;
    if (int'(shift) < WIDTH) w_exp = a << shift;
    for (int i = 1; i <= WIDTH; i++) begin
      if (int'(shift) == i) w_c = a[WIDTH-i];
    end
  end

  assign flags.n  = y[WIDTH-1];
  assign flags.z  = (y == '0);
  assign flags.c  = w_c;
  assign mismatch = (y != w_exp);

endmodule

// File: rtl/shift_result_stage.sv
// Buffers shifter results with n/z/c flags and a sticky result-check error.
// Latency: 1 cycle into an empty buffer; FIFO order.
// Backpressure: in_ready = registered occupancy < DEPTH, independent of out_ready.
module shift_result_stage
  import shift_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] shift,
  input  logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic             err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_en;
  logic            r_err;

  flags_t          w_flags;
  logic            w_mismatch;
  logic            w_push;
  logic            w_pop;
  entry_t          w_head;

  shift_flags #(.WIDTH(WIDTH)) u_flags (
    .a        (a),
    .shift    (shift),
    .y        (y),
    .flags    (w_flags),
    .mismatch (w_mismatch)
  );

  // r_en holds in_ready low until the first edge after reset release.
  assign in_ready  = r_en & (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign w_head    = r_mem[r_head];
  assign out_y     = w_head.y;
  assign out_n     = w_head.flags.n;
  assign out_z     = w_head.flags.z;
  assign out_c     = w_head.flags.c;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_push) begin
        r_mem[r_tail].y     <= y;
        r_mem[r_tail].flags <= w_flags;
        r_tail <= (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= (r_head == PW'(DEPTH - 1)) ? '0 : r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A coincident mismatching accept outranks the clear.
      if (w_push && w_mismatch) r_err <= 1'b1;
      else if (clr_err)         r_err <= 1'b0;
    end
  end

endmodule

// File: doc/shift_result_stage.md
SHIFT_RESULT_STAGE -- requirements
Module: shift_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the data width of the shifter feeding this stage.
REQ-002 SHALL have parameter DEPTH, default 2, giving the number of buffer entries; only DEPTH=2 is required to be supported.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the clock and reset ports are clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a  input  WIDTH  shifter operand, unshifted.
REQ-007 shift  input  WIDTH  shift amount applied by the upstream left logic shifter.
REQ-008 y  input  WIDTH  result produced by the upstream left logic shifter.
REQ-009 in_valid  input  1  a/shift/y are valid this cycle.
REQ-010 in_ready  output  1  stage can accept an entry this cycle.
REQ-011 out_y  output  WIDTH  buffered result, head entry.
REQ-012 out_n, out_z, out_c  output  1 each  negative, zero and carry flags of the head entry.
REQ-013 out_valid  output  1  head entry is valid.
REQ-014 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-015 clr_err  input  1  synchronous clear of err.
REQ-016 err  output  1  sticky flag: an accepted y differed from the expected shift result.

Function
REQ-017 SHALL accept an entry on a rising edge when in_valid && in_ready, and SHALL pop the head entry when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < DEPTH), where count is the registered occupancy; in_ready SHALL NOT depend combinationally on out_ready.
REQ-019 out_valid SHALL equal (count != 0), and out_y/out_n/out_z/out_c SHALL be driven from the head register only, with no combinational path from the input ports.
REQ-020 Latency SHALL be one cycle: an entry accepted at edge k appears at the head at edge k when the buffer was empty.
REQ-021 Entries SHALL leave the stage in acceptance order (FIFO).
REQ-022 A push and a pop in the same cycle SHALL leave count unchanged and keep ordering.
REQ-023 A pop with count=0 or a push with count=DEPTH SHALL be impossible by construction, and head/tail pointers SHALL wrap modulo DEPTH.
REQ-024 Flags SHALL be computed at acceptance: n=y[WIDTH-1]; z=(y==0); c=a[WIDTH-shift] for 1<=shift<=WIDTH, otherwise c=0.
REQ-025 The expected result SHALL be (a << shift) truncated to WIDTH bits, and equals 0 for shift>=WIDTH.
REQ-026 err SHALL be set on the edge after an accepted entry whose y differs from the expected result, and SHALL hold until reset or clr_err.
REQ-027 When clr_err and a mismatching accept coincide, err SHALL be 1 after the edge (set wins).

Reset
REQ-028 While rst_n=0: count=0, pointers=0, out_valid=0, in_ready=0, err=0, and out_y/out_n/out_z/out_c=0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries immediately and asynchronously.

Structure
REQ-031 Package shift_stage_pkg SHALL hold the flags_t struct {n,z,c}, the entry_t struct {y, flags_t}, and the DEPTH default.
REQ-032 Flag and expected-result computation SHALL live in a combinational sub-module shift_flags (inputs a, shift, y; outputs flags_t and mismatch).
REQ-033 Buffer storage SHALL be a flop array of entry_t with registered count, head and tail.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- a=1011, shift=1, y=0110, out_ready=1 -> next cycle out_y=0110, n=0, z=0, c=1, err=0.
- a=1000, shift=1, y=0000 -> z=1, c=1, n=0; a=1111, shift=2, y=1100 -> n=1, c=1, z=0.
- out_ready=0, push 0001/s1 (y=0010), 0011/s1 (y=0110), then a third in_valid -> in_ready=0 after 2 pushes, third not accepted; out_ready=1 -> 0010 then 0110 in order.
- count=1 with simultaneous push and pop for 4 cycles -> count stays 1, outputs appear in order.
- a=0101, shift=2, y=0101 (wrong) -> err=1 and sticky; clr_err=1 -> err=0; clr_err with coincident mismatch -> err=1.
- rst_n pulsed low with 2 entries buffered -> out_valid=0 and err=0 immediately; in_ready=1 one edge after release.
